// File: rtl/cpu_pkg.sv
// Shared definitions for the 12-bit register-file CPU: widths, instruction
// field layout, opcodes and controller state encoding.
package cpu_pkg;
  localparam int WORD_W  = 12;
  localparam int INSTR_W = 16;
  localparam int OP_W    = 3;
  localparam int REG_W   = 4;
  localparam int ALU_X_W = OP_W + 2 * WORD_W;

  localparam logic [OP_W-1:0] OP_NOP   = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b010;
  localparam logic [OP_W-1:0] OP_AND   = 3'b011;
  localparam logic [OP_W-1:0] OP_OR    = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b101;
  localparam logic [OP_W-1:0] OP_PASSA = 3'b110;
  localparam logic [OP_W-1:0] OP_PASSB = 3'b111;

  localparam int OP_HI    = 15;
  localparam int OP_LO    = 13;
  localparam int HALT_BIT = 12;
  localparam int RD_HI    = 11;
  localparam int RD_LO    = 8;
  localparam int RS1_HI   = 7;
  localparam int RS1_LO   = 4;
  localparam int RS2_HI   = 3;
  localparam int RS2_LO   = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
  } alu_x_t;
endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational split of an instruction word into its fields.
module cpu_instr_decode
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    op,
  output logic               halt,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rs1,
  output logic [REG_W-1:0]   rs2
);
  assign op   = instr[OP_HI:OP_LO];
  assign halt = instr[HALT_BIT];
  assign rd   = instr[RD_HI:RD_LO];
  assign rs1  = instr[RS1_HI:RS1_LO];
  assign rs2  = instr[RS2_HI:RS2_LO];
endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle sequencer: fetch, decode, execute (drive ALU word), writeback.
// Owns the program counter and the register-file write port.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int RF_AW   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [INSTR_W-1:0]  imem_data,
  output logic [RF_AW-1:0]    rf_ra1,
  output logic [RF_AW-1:0]    rf_ra2,
  input  logic [WORD_W-1:0]   rf_rd1,
  input  logic [WORD_W-1:0]   rf_rd2,
  output logic                rf_we,
  output logic [RF_AW-1:0]    rf_wa,
  output logic [WORD_W-1:0]   rf_wd,
  output logic [ALU_X_W-1:0]  alu_x,
  input  logic [WORD_W-1:0]   alu_y,
  output logic                busy,
  output logic                halted,
  output logic [IMEM_AW-1:0]  pc
);
  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic [INSTR_W-1:0] dec_in;
  logic [OP_W-1:0]    d_op;
  logic               d_halt;
  logic [REG_W-1:0]   d_rd, d_rs1, d_rs2;

  // In DECODE the fresh ROM word is decoded before it lands in ir, so the
  // register addresses are already stable when EXECUTE begins.
  assign dec_in = (state == S_DECODE) ? imem_data : ir;

  cpu_instr_decode u_dec (
    .instr (dec_in),
    .op    (d_op),
    .halt  (d_halt),
    .rd    (d_rd),
    .rs1   (d_rs1),
    .rs2   (d_rs2)
  );

  assign imem_addr = pc;
  // ALU result is combinational from the registered alu_x; only exposed while writing.
  assign rf_wd     = rf_we ? alu_y : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= '0;
      ir     <= '0;
      alu_x  <= '0;
      rf_we  <= 1'b0;
      rf_wa  <= '0;
      rf_ra1 <= '0;
      rf_ra2 <= '0;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc     <= '0;
            state  <= S_FETCH;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir <= imem_data;
          if (d_halt) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            rf_ra1 <= RF_AW'(d_rs1);
            rf_ra2 <= RF_AW'(d_rs2);
            rf_wa  <= RF_AW'(d_rd);
            state  <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          alu_x <= {d_op, rf_rd1, rf_rd2};
          rf_we <= (d_op != OP_NOP);
          state <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          pc    <= pc + 1'b1;
          state <= S_FETCH;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: ROM, register file and ALU models around the DUT,
// with an ISA-level scoreboard of expected register writes.
module tb_cpu_controller;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [3:0]  rf_ra1, rf_ra2, rf_wa;
  logic [11:0] rf_rd1, rf_rd2, rf_wd, alu_y;
  logic        rf_we, busy, halted;
  logic [26:0] alu_x;
  logic [7:0]  pc;

  logic [15:0] imem [256];
  logic [11:0] rf [16];
  logic        ld;
  logic [3:0]  ld_a;
  logic [11:0] ld_d;

  typedef struct {
    logic [26:0] x;
    logic [3:0]  wa;
    logic [11:0] wd;
  } exp_t;
  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cpu_controller #(.IMEM_AW(8), .RF_AW(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .alu_x(alu_x), .alu_y(alu_y),
    .busy(busy), .halted(halted), .pc(pc)
  );

  function automatic logic [11:0] alu_f(input logic [26:0] x);
    logic [11:0] a, b;
    a = x[23:12];
    b = x[11:0];
    case (x[26:24])
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_XOR:   return a ^ b;
      OP_PASSA: return a;
      OP_PASSB: return b;
      default:  return 12'h000;
    endcase
  endfunction

  assign alu_y  = alu_f(alu_x);
  assign rf_rd1 = rf[rf_ra1];
  assign rf_rd2 = rf[rf_ra2];

  always @(posedge clk) imem_data <= imem[imem_addr];

  always @(posedge clk) begin
    if (rf_we) rf[rf_wa] <= rf_wd;
    else if (ld) rf[ld_a] <= ld_d;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) chk("we_spurious", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_alu_x", 32'(alu_x), 32'(e.x));
        chk("sb_rf_wa", 32'(rf_wa), 32'(e.wa));
        chk("sb_rf_wd", 32'(rf_wd), 32'(e.wd));
      end
    end
  end

  task automatic set_reg(input logic [3:0] a, input logic [11:0] d);
    @(negedge clk);
    ld = 1'b1; ld_a = a; ld_d = d;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  // ISA-level reference: run the program from pc 0 on a copy of the register file.
  task automatic model_prog();
    logic [11:0] s [16];
    logic [15:0] ins;
    logic [7:0]  p;
    exp_t e;
    for (int i = 0; i < 16; i++) s[i] = rf[i];
    p = 8'd0;
    for (int n = 0; n < 300; n++) begin
      ins = imem[p];
      if (ins[12]) break;
      if (ins[15:13] != 3'b000) begin
        e.x  = {ins[15:13], s[ins[7:4]], s[ins[3:0]]};
        e.wa = ins[11:8];
        e.wd = alu_f(e.x);
        exp_q.push_back(e);
        s[ins[11:8]] = e.wd;
      end
      p = p + 8'd1;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (halted !== 1'b1) chk("halt_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ld = 1'b0; ld_a = '0; ld_d = '0;
    for (int i = 0; i < 256; i++) imem[i] = 16'h1000;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_ra", 32'({rf_ra1, rf_ra2}), 0);
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_wa_wd", 32'({rf_wa, rf_wd}), 0);
    chk("rst_alu_x", 32'(alu_x), 0);
    chk("rst_busy_halt", 32'({busy, halted}), 0);
    chk("rst_pc", 32'(pc), 0);
    rst = 1'b0;

    // single ADD r3 = r1 + r2, then halt
    set_reg(4'd1, 12'd5);
    set_reg(4'd2, 12'd7);
    imem[0] = 16'h2312; imem[1] = 16'h1000;
    model_prog();
    pulse_start();
    repeat (3) @(negedge clk);
    chk("add_we_c3", 32'(rf_we), 0);
    @(negedge clk);
    chk("add_we_c4", 32'(rf_we), 1);
    chk("add_alu_x", 32'(alu_x), 32'({3'b001, 12'd5, 12'd7}));
    chk("add_wa", 32'(rf_wa), 3);
    chk("add_wd", 32'(rf_wd), 12);
    @(negedge clk);
    chk("add_we_c5", 32'(rf_we), 0);
    chk("add_pc", 32'(pc), 1);
    wait_halt(20);
    chk("add_halt_pc", 32'(pc), 1);

    // NOP then halt, then restart from HALT
    imem[0] = 16'h0312; imem[1] = 16'h1000;
    pulse_start();
    repeat (6) @(negedge clk);
    chk("nop_halt_c6", 32'(halted), 0);
    @(negedge clk);
    chk("nop_halt_c7", 32'(halted), 1);
    chk("nop_pc", 32'(pc), 1);
    repeat (3) @(negedge clk);
    chk("nop_hold", 32'({halted, busy, pc}), 32'({1'b1, 1'b0, 8'd1}));
    pulse_start();
    @(negedge clk);
    chk("restart", 32'({halted, busy, pc}), 32'({1'b0, 1'b1, 8'd0}));
    wait_halt(20);

    // back-to-back dependency through r3, r4 = r3 + r3
    set_reg(4'd3, 12'd0);
    imem[0] = 16'h2312; imem[1] = 16'h2433; imem[2] = 16'h1000;
    model_prog();
    pulse_start();
    wait_halt(40);
    chk("raw_alu_x", 32'(alu_x), 32'({3'b001, 12'd12, 12'd12}));
    chk("raw_pc", 32'(pc), 2);

    // mixed ops, rd=rs1=rs2, underflow, and a start pulse while busy
    set_reg(4'd5, 12'h900);
    imem[0] = 16'h4621; imem[1] = 16'hA762; imem[2] = 16'h2555;
    imem[3] = 16'h4812; imem[4] = 16'h1000;
    model_prog();
    pulse_start();
    repeat (6) @(negedge clk);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_halt(60);
    chk("mix_pc", 32'(pc), 4);

    // pc wrap over 256 NOPs; address 0 becomes a halt after its first fetch
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    pulse_start();
    repeat (10) @(negedge clk);
    imem[0] = 16'h1000;
    repeat (1011) @(negedge clk);
    chk("wrap_pc255", 32'(pc), 255);
    repeat (4) @(negedge clk);
    chk("wrap_pc0", 32'({busy, pc}), 32'({1'b1, 8'd0}));
    repeat (2) @(negedge clk);
    chk("wrap_halt", 32'({halted, pc}), 32'({1'b1, 8'd0}));

    // reset during EXECUTE: no write may escape
    imem[0] = 16'h2312; imem[1] = 16'h1000;
    pulse_start();
    repeat (3) @(negedge clk);
    chk("mr_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mr_async", 32'({rf_we, busy, halted, pc}), 0);
    chk("mr_alu_x", 32'(alu_x), 0);
    @(negedge clk);
    chk("mr_we_hold", 32'(rf_we), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mr_idle", 32'({rf_we, busy, halted, pc}), 0);

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
